// File: rtl/amm_rdwr_arbiter.sv
// Round-robin share of one Avalon-MM master between a read-only and a write-only requester.
// Registered grant, combinational command mux; one transfer per grant, pipelined reads counted.
module amm_rdwr_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 64,
  parameter int MAX_PENDING_RD = 8,
  parameter int RD_FENCE       = 1,
  localparam int BE_W          = DATA_W / 8,
  localparam int PEND_W        = $clog2(MAX_PENDING_RD + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd_address_i,
  input  logic              rd_read_i,
  output logic              rd_waitrequest_o,
  output logic [DATA_W-1:0] rd_readdata_o,
  output logic              rd_readdatavalid_o,
  input  logic [ADDR_W-1:0] wr_address_i,
  input  logic              wr_write_i,
  input  logic [DATA_W-1:0] wr_writedata_i,
  input  logic [BE_W-1:0]   wr_byteenable_i,
  output logic              wr_waitrequest_o,
  output logic [ADDR_W-1:0] amm_address_o,
  output logic              amm_read_o,
  output logic              amm_write_o,
  output logic [DATA_W-1:0] amm_writedata_o,
  output logic [BE_W-1:0]   amm_byteenable_o,
  input  logic              amm_waitrequest_i,
  input  logic [DATA_W-1:0] amm_readdata_i,
  input  logic              amm_readdatavalid_i,
  output logic [PEND_W-1:0] rd_pending_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, GNT_RD, GNT_WR} state_t;

  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PENDING_RD);

  state_t            state;
  logic              last_gnt_wr;
  logic [PEND_W-1:0] pending;
  logic              err;
  logic              rd_ok;
  logic              wr_ok;
  logic              rd_accept;

  assign rd_ok     = rd_read_i && (pending < MAX_P);
  assign wr_ok     = wr_write_i && ((RD_FENCE == 0) || (pending == '0));
  assign rd_accept = (state == GNT_RD) && rd_read_i && !amm_waitrequest_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      last_gnt_wr <= 1'b1;
      pending     <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // On contention the port that did not win last time goes first.
          if (rd_ok && (!wr_ok || last_gnt_wr)) begin
            state       <= GNT_RD;
            last_gnt_wr <= 1'b0;
          end else if (wr_ok) begin
            state       <= GNT_WR;
            last_gnt_wr <= 1'b1;
          end
        end
        GNT_RD: if (!rd_read_i || !amm_waitrequest_i) state <= IDLE;
        GNT_WR: if (!wr_write_i || !amm_waitrequest_i) state <= IDLE;
        default: state <= IDLE;
      endcase

      // A return with nothing outstanding is flagged rather than wrapping the count.
      if (rd_accept && !amm_readdatavalid_i) begin
        pending <= pending + PEND_W'(1);
      end else if (!rd_accept && amm_readdatavalid_i) begin
        if (pending == '0) err <= 1'b1;
        else               pending <= pending - PEND_W'(1);
      end
    end
  end

  always_comb begin
    amm_address_o    = '0;
    amm_read_o       = 1'b0;
    amm_write_o      = 1'b0;
    amm_writedata_o  = '0;
    amm_byteenable_o = '0;
    rd_waitrequest_o = 1'b1;
    wr_waitrequest_o = 1'b1;
    case (state)
      GNT_RD: begin
        amm_address_o    = rd_address_i;
        amm_read_o       = rd_read_i;
        amm_byteenable_o = '1;
        rd_waitrequest_o = amm_waitrequest_i;
      end
      GNT_WR: begin
        amm_address_o    = wr_address_i;
        amm_write_o      = wr_write_i;
        amm_writedata_o  = wr_writedata_i;
        amm_byteenable_o = wr_byteenable_i;
        wr_waitrequest_o = amm_waitrequest_i;
      end
      default: ;
    endcase
  end

  assign rd_readdata_o      = amm_readdata_i;
  assign rd_readdatavalid_o = amm_readdatavalid_i;
  assign rd_pending_o       = pending;
  assign err_o              = err;

endmodule

// File: tb/tb_amm_rdwr_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences for stall, depth limit, fence and reset.
module tb_amm_rdwr_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;
  localparam int PW     = 4;
  localparam int N = 0, R = 1, W = 2;

  localparam logic [ADDR_W-1:0] RD_ADDR = 10'h010;
  localparam logic [ADDR_W-1:0] WR_ADDR = 10'h3FF;
  localparam logic [DATA_W-1:0] WR_DATA = 64'hDEADBEEF_0000FFFF;
  localparam logic [BE_W-1:0]   WR_BE   = 8'h0F;
  localparam logic [DATA_W-1:0] RD_DATA = 64'hA5A5_0123_4567_89AB;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic rd_read = 1'b0, wr_write = 1'b0, amm_wait = 1'b0, amm_rdv = 1'b0;

  logic              rd_wait0, rd_rdv0, wr_wait0, amm_read0, amm_write0, err0;
  logic [DATA_W-1:0] rd_data0, amm_wdata0;
  logic [ADDR_W-1:0] amm_addr0;
  logic [BE_W-1:0]   amm_be0;
  logic [PW-1:0]     pend0;

  logic              rd_wait1, rd_rdv1, wr_wait1, amm_read1, amm_write1, err1;
  logic [DATA_W-1:0] rd_data1, amm_wdata1;
  logic [ADDR_W-1:0] amm_addr1;
  logic [BE_W-1:0]   amm_be1;
  logic [PW-1:0]     pend1;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  amm_rdwr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING_RD(8), .RD_FENCE(1)) u0 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rd_address_i(RD_ADDR), .rd_read_i(rd_read), .rd_waitrequest_o(rd_wait0),
    .rd_readdata_o(rd_data0), .rd_readdatavalid_o(rd_rdv0),
    .wr_address_i(WR_ADDR), .wr_write_i(wr_write), .wr_writedata_i(WR_DATA),
    .wr_byteenable_i(WR_BE), .wr_waitrequest_o(wr_wait0),
    .amm_address_o(amm_addr0), .amm_read_o(amm_read0), .amm_write_o(amm_write0),
    .amm_writedata_o(amm_wdata0), .amm_byteenable_o(amm_be0),
    .amm_waitrequest_i(amm_wait), .amm_readdata_i(RD_DATA), .amm_readdatavalid_i(amm_rdv),
    .rd_pending_o(pend0), .err_o(err0)
  );

  amm_rdwr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING_RD(8), .RD_FENCE(0)) u1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rd_address_i(RD_ADDR), .rd_read_i(rd_read), .rd_waitrequest_o(rd_wait1),
    .rd_readdata_o(rd_data1), .rd_readdatavalid_o(rd_rdv1),
    .wr_address_i(WR_ADDR), .wr_write_i(wr_write), .wr_writedata_i(WR_DATA),
    .wr_byteenable_i(WR_BE), .wr_waitrequest_o(wr_wait1),
    .amm_address_o(amm_addr1), .amm_read_o(amm_read1), .amm_write_o(amm_write1),
    .amm_writedata_o(amm_wdata1), .amm_byteenable_o(amm_be1),
    .amm_waitrequest_i(amm_wait), .amm_readdata_i(RD_DATA), .amm_readdatavalid_i(amm_rdv),
    .rd_pending_o(pend1), .err_o(err1)
  );

  typedef struct {
    bit rd; bit wr; bit w; bit v;
    int gnt; int pend; bit err;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rd_read = 0; wr_write = 0; amm_wait = 0; amm_rdv = 0;
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    step();
  endtask

  initial begin
    int acc;
    int found;
    int exp_alt[8];

    // rd wr wait rdv | grant pending err
    vt[0]  = '{0,0,0,0, N,0,0};
    vt[1]  = '{1,0,0,0, N,0,0};
    vt[2]  = '{1,0,0,0, R,0,0};
    vt[3]  = '{0,0,0,0, N,1,0};
    vt[4]  = '{0,0,0,1, N,1,0};
    vt[5]  = '{0,0,0,0, N,0,0};
    vt[6]  = '{0,1,0,0, N,0,0};
    vt[7]  = '{0,1,1,0, W,0,0};
    vt[8]  = '{0,1,0,0, W,0,0};
    vt[9]  = '{0,0,0,0, N,0,0};
    vt[10] = '{0,0,0,1, N,0,0};
    vt[11] = '{0,0,0,0, N,0,1};
    vt[12] = '{1,1,0,0, N,0,1};
    vt[13] = '{1,1,0,0, R,0,1};
    vt[14] = '{0,1,0,0, N,1,1};
    vt[15] = '{0,1,0,1, N,1,1};
    vt[16] = '{0,1,0,0, N,0,1};
    vt[17] = '{0,1,0,0, W,0,1};
    vt[18] = '{1,0,0,0, N,0,1};
    vt[19] = '{0,0,1,0, R,0,1};
    vt[20] = '{0,0,0,0, N,0,1};

    // Reset values before any clock edge releases reset.
    #2;
    chk("reset amm_read", amm_read0, 0);
    chk("reset amm_write", amm_write0, 0);
    chk("reset rd_wait", rd_wait0, 1);
    chk("reset wr_wait", wr_wait0, 1);
    chk("reset pending", pend0, 0);
    chk("reset err", err0, 0);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      rd_read = vt[i].rd; wr_write = vt[i].wr; amm_wait = vt[i].w; amm_rdv = vt[i].v;
      #1;
      chk($sformatf("row%0d amm_read", i), amm_read0, (vt[i].gnt == R) && vt[i].rd);
      chk($sformatf("row%0d amm_write", i), amm_write0, (vt[i].gnt == W) && vt[i].wr);
      chk($sformatf("row%0d rd_wait", i), rd_wait0, (vt[i].gnt == R) ? vt[i].w : 1'b1);
      chk($sformatf("row%0d wr_wait", i), wr_wait0, (vt[i].gnt == W) ? vt[i].w : 1'b1);
      chk($sformatf("row%0d addr", i), amm_addr0,
          (vt[i].gnt == R) ? RD_ADDR : (vt[i].gnt == W) ? WR_ADDR : '0);
      chk($sformatf("row%0d be", i), amm_be0,
          (vt[i].gnt == R) ? 8'hFF : (vt[i].gnt == W) ? WR_BE : 8'h00);
      if (vt[i].gnt != R)
        chk($sformatf("row%0d wdata", i), amm_wdata0, (vt[i].gnt == W) ? WR_DATA : '0);
      chk($sformatf("row%0d pending", i), pend0, vt[i].pend);
      chk($sformatf("row%0d err", i), err0, vt[i].err);
      chk($sformatf("row%0d rdv", i), rd_rdv0, vt[i].v);
      chk($sformatf("row%0d rdata", i), rd_data0, RD_DATA);
      step();
    end

    // Alternation with both held (fence off so writes are not blocked by pending reads).
    exp_alt = '{N, R, N, W, N, R, N, W};
    do_reset();
    rd_read = 1; wr_write = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("alt%0d grant", i), amm_read1 ? R : amm_write1 ? W : N, exp_alt[i]);
      if (i == 1) chk("alt fenced first grant rd", amm_read0, 1);
      step();
    end

    // Write stalled 5 cycles by the slave: command must hold steady.
    do_reset();
    wr_write = 1; amm_wait = 1;
    step();
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("stall%0d write", c), amm_write0, 1);
      chk($sformatf("stall%0d addr", c), amm_addr0, WR_ADDR);
      chk($sformatf("stall%0d data", c), amm_wdata0, WR_DATA);
      chk($sformatf("stall%0d be", c), amm_be0, WR_BE);
      chk($sformatf("stall%0d wr_wait", c), wr_wait0, 1);
      step();
    end
    amm_wait = 0;
    #1;
    chk("stall6 write", amm_write0, 1);
    chk("stall6 wr_wait", wr_wait0, 0);
    step();
    wr_write = 0;
    #1 chk("stall after accept write", amm_write0, 0);

    // Depth limit: nine reads, no returns, only eight get through.
    do_reset();
    rd_read = 1;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      #1 if (amm_read0 && !amm_wait) acc++;
      step();
    end
    chk("depth accepted", acc, 8);
    chk("depth pending", pend0, 8);
    #1 chk("depth ninth held", amm_read0, 0);
    amm_rdv = 1;
    step();
    amm_rdv = 0;
    found = 0;
    for (int c = 0; c < 6 && found == 0; c++) begin
      #1 if (amm_read0) found = 1;
      step();
    end
    chk("depth ninth accepted", found, 1);
    chk("depth pending refill", pend0, 8);
    chk("depth err", err0, 0);

    // Fence: three reads outstanding, write requested.
    do_reset();
    rd_read = 1;
    for (int c = 0; c < 20 && pend0 != 3; c++) step();
    rd_read = 0;
    chk("fence pending3", pend0, 3);
    wr_write = 1;
    acc = 0; found = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (amm_write0) acc++;
      if (amm_write1) found = 1;
      step();
    end
    chk("fence blocks write", acc, 0);
    chk("nofence grants write", found, 1);
    for (int k = 0; k < 3; k++) begin
      amm_rdv = 1; step(); amm_rdv = 0;
      #1 chk($sformatf("fence blocked after rdv%0d", k), amm_write0, 0);
      step();
    end
    chk("fence pending drained", pend0, 0);
    found = 0;
    for (int c = 0; c < 4 && found == 0; c++) begin
      #1 if (amm_write0) found = 1;
      step();
    end
    chk("fence write after drain", found, 1);
    wr_write = 0;

    // Stray readdatavalid, then async reset in the middle of a write grant.
    do_reset();
    amm_rdv = 1;
    step();
    amm_rdv = 0;
    chk("stray err set", err0, 1);
    chk("stray pending", pend0, 0);
    step(); step();
    chk("stray err sticky", err0, 1);
    wr_write = 1; amm_wait = 1;
    step();
    #1 chk("grant wr before reset", amm_write0, 1);
    #2 rst_ni = 0;
    #1;
    chk("mid reset amm_write", amm_write0, 0);
    chk("mid reset wr_wait", wr_wait0, 1);
    chk("mid reset err", err0, 0);
    wr_write = 0; amm_wait = 0;
    @(posedge clk_i);
    #1 rst_ni = 1;
    step();
    amm_rdv = 1;
    step();
    amm_rdv = 0;
    chk("post reset rdv err", err0, 1);
    chk("post reset pending", pend0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
